add16_chain: RTL
================

# add16_chain

Sequencing initiator that performs a 16-bit add by issuing two 8-bit requests, low byte then high byte, to an external enable/ready 8-bit adder unit (ripple_cla8-class). It chains the low-byte carry into the high-byte request. It sits between the datapath controller, which issues 16-bit operations with a start pulse, and the 8-bit adder, which it drives through that adder's `en`/`ready` handshake. A watchdog aborts the operation if the adder never answers.

## Interface
Parameters
- `TIMEOUT`, 15: maximum cycles one adder request may stay outstanding; legal range 1..255.

Ports
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a 16-bit add; sampled only in IDLE.
- `a` in 16: operand A; latched when `start` is accepted.
- `b` in 16: operand B; latched when `start` is accepted.
- `cin` in 1: carry-in; latched when `start` is accepted.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; `sum`, `cout` and `err` are valid in that cycle.
- `sum` out 16: result; held until the next accepted `start`.
- `cout` out 1: carry out of bit 15; held like `sum`.
- `err` out 1: high only with `done` when the operation timed out.
- `add_en` out 1: request to the adder (drives the adder's `en`).
- `add_a` out 8: byte operand A for the adder.
- `add_b` out 8: byte operand B for the adder.
- `add_cin` out 1: carry-in for the adder.
- `add_ready` in 1: adder completion; must be high for at least 1 cycle.
- `add_sum` in 8: adder result (the adder's `Output`).
- `add_cout` in 1: adder carry out (the adder's `c_out`).

## Operation
- Adder protocol, fixed:
  - `add_en` rises with `add_a`, `add_b` and `add_cin` stable.
  - Those inputs stay stable while `add_en` is high.
  - The adder raises `add_ready` no earlier than 1 cycle after `add_en` rises.
  - `add_sum` and `add_cout` are valid while `add_ready` is high.
  - After capturing the result, the initiator drops `add_en` for at least 1 full cycle before the next request.
- States: IDLE, LO_REQ, LO_GAP, HI_REQ, DONE.
- IDLE: `start`=1 latches `a`, `b` and `cin`, clears `sum`, `cout` and `err`, then goes to LO_REQ.
- LO_REQ:
  - Drives `add_en`=1, `add_a`=a[7:0], `add_b`=b[7:0], `add_cin`=cin.
  - If `add_ready`: sum[7:0]←`add_sum`, internal carry←`add_cout`, go to LO_GAP.
- LO_GAP: `add_en`=0 for exactly one cycle, then go to HI_REQ.
- HI_REQ:
  - Drives `add_en`=1, `add_a`=a[15:8], `add_b`=b[15:8], `add_cin`=latched carry.
  - If `add_ready`: sum[15:8]←`add_sum`, `cout`←`add_cout`, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Watchdog, in LO_REQ and HI_REQ only:
  - The counter starts at 1 on entry to the state and increments each cycle.
  - If `add_ready` is still low in the cycle where count = `TIMEOUT`: `sum`←0, `cout`←0, `err`←1, go to DONE.
  - `add_ready` high in that same cycle wins; the operation proceeds normally.
- `add_ready` outside LO_REQ and HI_REQ is ignored.
- `start` while `busy` is ignored; it is not queued.
- `add_a`, `add_b` and `add_cin` read 0 whenever `add_en`=0.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `err`=0, `sum`=0, `cout`=0, `add_en`=0, `add_a`=0, `add_b`=0, `add_cin`=0.
- Reset mid-operation: the next edge returns everything to the reset values.
  - `add_en` is low from the cycle after reset is sampled.
  - No `done` is produced for the aborted operation.
- `start` sampled at edge k0 gives `busy`=1 and `add_en`=1 from cycle k0+1.
- With adder latency L (cycles from `add_en` rise to `add_ready`, L≥1):
  - Low-byte `add_ready` at k0+1+L.
  - LO_GAP at k0+2+L.
  - HI_REQ at k0+3+L.
  - `done` at k0+4+2L.
- `busy` falls in the cycle after `done`; the earliest next `start` is accepted at that IDLE edge.
- Timeout in LO_REQ: `done`=`err`=1 at k0+1+`TIMEOUT`.
- All outputs are registered; there are no combinational paths from `add_ready` to `add_en`.

## Test plan
- Adder model L=2, a=0x000C, b=0x0001, cin=1 → `add_en` high k0+1..k0+3, low k0+4, high k0+5..k0+7; `done` at k0+8; sum=0x000E, cout=0, err=0.
- Carry chain: a=0x12FF, b=0x0001, cin=0 → high request carries `add_cin`=1; sum=0x1300, cout=0.
- Overflow: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1.
- Adder never asserts `add_ready`, TIMEOUT=15 → `add_en` high k0+1..k0+15; `done`=`err`=1 at k0+16; sum=0, cout=0; then IDLE.
- `add_ready` arrives exactly on cycle 15 of LO_REQ (TIMEOUT=15) → no error; the operation completes with the correct sum.
- `reset` pulsed during HI_REQ, plus `start` pulsed while busy → after reset all outputs are 0 and there is no `done`; a busy-time `start` produces no extra operation.

Source files
------------

// File: rtl/add16_chain.sv
// add16_chain: performs a 16-bit add as two 8-bit requests (low byte, then
// high byte) to an external enable/ready 8-bit adder. The low-byte carry is
// chained into the high-byte request. A per-request watchdog aborts the
// operation with err if the adder never answers.
module add16_chain #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        cout,
  output logic        err,
  output logic        add_en,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  output logic        add_cin,
  input  logic        add_ready,
  input  logic [7:0]  add_sum,
  input  logic        add_cout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LO_REQ = 3'd1,
    LO_GAP = 3'd2,
    HI_REQ = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Watchdog compare value; TIMEOUT is limited to 1..255 so 8 bits suffice.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_reg, state_next;
  logic [15:0] a_reg, a_next;
  logic [15:0] b_reg, b_next;
  logic        cin_reg, cin_next;
  logic        carry_reg, carry_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [15:0] sum_reg, sum_next;
  logic        cout_reg, cout_next;
  logic        err_reg, err_next;
  logic        done_reg, done_next;
  logic        busy_reg, busy_next;
  logic        add_en_reg, add_en_next;
  logic [7:0]  add_a_reg, add_a_next;
  logic [7:0]  add_b_reg, add_b_next;
  logic        add_cin_reg, add_cin_next;

  // Next-state and next-output computation; every output is derived from the
  // next state so that all ports come straight from flops.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    cin_next   = cin_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          cin_next   = cin;
          sum_next   = 16'h0000;
          cout_next  = 1'b0;
          cnt_next   = 8'd1;
          state_next = LO_REQ;
        end
      end

      LO_REQ: begin
        // A response in the final watchdog cycle still counts as success.
        if (add_ready) begin
          sum_next   = {sum_reg[15:8], add_sum};
          carry_next = add_cout;
          state_next = LO_GAP;
        end else if (cnt_reg == TIMEOUT_CNT) begin
          sum_next   = 16'h0000;
          cout_next  = 1'b0;
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      LO_GAP: begin
        cnt_next   = 8'd1;
        state_next = HI_REQ;
      end

      HI_REQ: begin
        if (add_ready) begin
          sum_next   = {add_sum, sum_reg[7:0]};
          cout_next  = add_cout;
          state_next = DONE;
        end else if (cnt_reg == TIMEOUT_CNT) begin
          sum_next   = 16'h0000;
          cout_next  = 1'b0;
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Registered status and adder-request outputs, aligned with state_next.
    busy_next    = (state_next != IDLE);
    done_next    = (state_next == DONE);
    add_en_next  = 1'b0;
    add_a_next   = 8'h00;
    add_b_next   = 8'h00;
    add_cin_next = 1'b0;
    if (state_next == LO_REQ) begin
      add_en_next  = 1'b1;
      add_a_next   = a_next[7:0];
      add_b_next   = b_next[7:0];
      add_cin_next = cin_next;
    end else if (state_next == HI_REQ) begin
      add_en_next  = 1'b1;
      add_a_next   = a_next[15:8];
      add_b_next   = b_next[15:8];
      add_cin_next = carry_next;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      a_reg       <= 16'h0000;
      b_reg       <= 16'h0000;
      cin_reg     <= 1'b0;
      carry_reg   <= 1'b0;
      cnt_reg     <= 8'd0;
      sum_reg     <= 16'h0000;
      cout_reg    <= 1'b0;
      err_reg     <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      add_en_reg  <= 1'b0;
      add_a_reg   <= 8'h00;
      add_b_reg   <= 8'h00;
      add_cin_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      cin_reg     <= cin_next;
      carry_reg   <= carry_next;
      cnt_reg     <= cnt_next;
      sum_reg     <= sum_next;
      cout_reg    <= cout_next;
      err_reg     <= err_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
      add_en_reg  <= add_en_next;
      add_a_reg   <= add_a_next;
      add_b_reg   <= add_b_next;
      add_cin_reg <= add_cin_next;
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign sum     = sum_reg;
  assign cout    = cout_reg;
  assign err     = err_reg;
  assign add_en  = add_en_reg;
  assign add_a   = add_a_reg;
  assign add_b   = add_b_reg;
  assign add_cin = add_cin_reg;

endmodule
